// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiters.
package mem_arb_pkg;

  localparam int unsigned MAX_DATA_RUN_DEF = 4;
  localparam int unsigned RUN_W            = 4;
  localparam int unsigned BE_W             = 4;
  localparam logic [BE_W-1:0] BE_ALL       = '1;

  // Tag naming which requester receives next-cycle read data
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DR   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arb_run_ctr.sv
// Counts consecutive contested grants to the favoured requester and flags
// when the other requester must be forced through.
module mem_arb_run_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_RUN = MAX_DATA_RUN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_fetch_c
);

  logic [RUN_W-1:0] run_q;

  // Run length register; clear has priority and the count stops at MAX_RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
    end else if (clr) begin
      run_q <= '0;
    end else if (inc && (run_q != RUN_W'(MAX_RUN))) begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign force_fetch_c = (run_q == RUN_W'(MAX_RUN));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. Data wins by default; a run limit forces fetch through.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_be,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [CNT_W-1:0]    o_conflict_cnt
);

  owner_e owner_q, owner_d;
  logic              if_gnt_c, d_gnt_c, force_fetch_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [CNT_W-1:0]  conflict_q;

  mem_arb_run_ctr #(.MAX_RUN(MAX_DATA_RUN)) u_run_ctr (
    .clk           (clk),
    .reset         (i_reset),
    .inc           (d_gnt_c & i_if_req),
    .clr           (if_gnt_c | ~i_if_req),
    .force_fetch_c (force_fetch_c)
  );

  // Grant selection: data favoured unless its contested run hit the limit
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!i_reset) begin
      if (i_if_req && i_d_req) begin
        if (force_fetch_c) if_gnt_c = 1'b1;
        else               d_gnt_c  = 1'b1;
      end else if (i_if_req) begin
        if_gnt_c = 1'b1;
      end else if (i_d_req) begin
        d_gnt_c = 1'b1;
      end
    end
  end

  // RAM port mux from the winner; idle port keeps we/be low
  always_comb begin
    sel_addr_c  = i_d_addr;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_wdata = i_d_wdata;
    if (if_gnt_c) begin
      sel_addr_c = i_if_addr;
      o_mem_be   = BE_ALL;
    end else if (d_gnt_c) begin
      o_mem_we = i_d_we;
      o_mem_be = i_d_be;
    end
  end

  assign o_mem_addr = sel_addr_c & ~ADDR_W'(3);
  assign o_mem_en   = if_gnt_c | d_gnt_c;
  assign o_if_gnt   = if_gnt_c;
  assign o_d_gnt    = d_gnt_c;

  // Owner next state: a read grant tags next-cycle data, anything else clears
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt_c)                owner_d = OWN_IF;
    else if (d_gnt_c && !i_d_we) owner_d = OWN_DR;
  end

  // Owner state register
  always_ff @(posedge clk) begin
    if (i_reset) owner_q <= OWN_NONE;
    else         owner_q <= owner_d;
  end

  // Read return is silenced while reset is held so an in-flight read is dropped
  assign o_if_rvalid = (owner_q == OWN_IF) & ~i_reset;
  assign o_d_rvalid  = (owner_q == OWN_DR) & ~i_reset;
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

  // Saturating count of cycles where both requesters asked
  always_ff @(posedge clk) begin
    if (i_reset) begin
      conflict_q <= '0;
    end else if (i_if_req && i_d_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + CNT_W'(1);
    end
  end

  assign o_conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [15:0] cnt16;

  logic        s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_mem_en, s_mem_we;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_be;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_be(d_be), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_conflict_cnt(cnt16)
  );

  mem_port_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(s_if_gnt),
    .o_if_rvalid(s_if_rvalid), .o_if_rdata(s_if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_be(d_be), .o_d_gnt(s_d_gnt), .o_d_rvalid(s_d_rvalid), .o_d_rdata(s_d_rdata),
    .o_mem_en(s_mem_en), .o_mem_we(s_mem_we), .o_mem_be(s_mem_be),
    .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata), .i_mem_rdata(mem_rdata),
    .o_conflict_cnt(cnt4)
  );

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dr, dwe;
    logic [31:0] da, dwd;
    logic [3:0]  dbe;
    logic [31:0] rd;
    logic        e_ig, e_dg, e_en, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic        e_irv, e_drv;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t v(
    input logic r, input logic ifr, input logic [31:0] ifa,
    input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] dbe, input logic [31:0] rd,
    input logic eig, input logic edg, input logic een, input logic ewe,
    input logic [3:0] ebe, input logic [31:0] eaddr,
    input logic eirv, input logic edrv, input logic [15:0] ecnt);
    vec_t t;
    t.rst = r; t.ifr = ifr; t.ifa = ifa; t.dr = dr; t.dwe = dwe; t.da = da;
    t.dwd = dwd; t.dbe = dbe; t.rd = rd; t.e_ig = eig; t.e_dg = edg;
    t.e_en = een; t.e_we = ewe; t.e_be = ebe; t.e_addr = eaddr;
    t.e_irv = eirv; t.e_drv = edrv; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [vec %0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    //                 rst ifr ifa     dr dwe da       dwd      dbe  rd              ig dg en we be   addr     irv drv cnt
    vecs[0]  = v(1, 1, 32'h08, 1, 0, 32'h100, 0,        4'hF, 0,              0, 0, 0, 0, 4'h0, 32'h0,   0, 0, 0);
    vecs[1]  = v(0, 1, 32'h08, 0, 0, 32'h0,   0,        4'h0, 0,              1, 0, 1, 0, 4'hF, 32'h08,  0, 0, 0);
    vecs[2]  = v(0, 0, 32'h0,  0, 0, 32'h0,   0,        4'h0, 32'hE3A01041,   0, 0, 0, 0, 4'h0, 32'h0,   1, 0, 0);
    vecs[3]  = v(0, 1, 32'h10, 1, 0, 32'h100, 0,        4'hF, 0,              0, 1, 1, 0, 4'hF, 32'h100, 0, 0, 0);
    vecs[4]  = v(0, 1, 32'h10, 0, 0, 32'h0,   0,        4'h0, 32'h12345678,   1, 0, 1, 0, 4'hF, 32'h10,  0, 1, 1);
    vecs[5]  = v(0, 0, 32'h0,  1, 1, 32'h203, 32'hBEEF, 4'h3, 32'hCAFEF00D,   0, 1, 1, 1, 4'h3, 32'h200, 1, 0, 1);
    vecs[6]  = v(0, 0, 32'h0,  0, 0, 32'h0,   0,        4'h0, 32'h0BADF00D,   0, 0, 0, 0, 4'h0, 32'h0,   0, 0, 1);
    vecs[7]  = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h11,         0, 1, 1, 0, 4'hF, 32'h80,  0, 0, 1);
    vecs[8]  = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h22,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 2);
    vecs[9]  = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h33,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 3);
    vecs[10] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h44,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 4);
    vecs[11] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h55,         1, 0, 1, 0, 4'hF, 32'h40,  0, 1, 5);
    vecs[12] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'h66,         0, 1, 1, 0, 4'hF, 32'h80,  1, 0, 6);
    vecs[13] = v(0, 0, 32'h0,  0, 0, 32'h0,   0,        4'h0, 32'h77,         0, 0, 0, 0, 4'h0, 32'h0,   0, 1, 7);
    vecs[14] = v(0, 0, 32'h0,  1, 0, 32'h300, 0,        4'hF, 32'h88,         0, 1, 1, 0, 4'hF, 32'h300, 0, 0, 7);
    vecs[15] = v(1, 1, 32'h40, 1, 0, 32'h300, 0,        4'hF, 32'h99,         0, 0, 0, 0, 4'h0, 32'h0,   0, 0, 7);
    vecs[16] = v(1, 1, 32'h40, 1, 0, 32'h300, 0,        4'hF, 32'hAA,         0, 0, 0, 0, 4'h0, 32'h0,   0, 0, 0);
    vecs[17] = v(0, 0, 32'h0,  0, 0, 32'h0,   0,        4'h0, 32'hBB,         0, 0, 0, 0, 4'h0, 32'h0,   0, 0, 0);
    vecs[18] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'hC1,         0, 1, 1, 0, 4'hF, 32'h80,  0, 0, 0);
    vecs[19] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'hC2,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 1);
    vecs[20] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'hC3,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 2);
    vecs[21] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'hC4,         0, 1, 1, 0, 4'hF, 32'h80,  0, 1, 3);
    vecs[22] = v(0, 1, 32'h40, 1, 0, 32'h80,  0,        4'hF, 32'hC5,         1, 0, 1, 0, 4'hF, 32'h40,  0, 1, 4);
    vecs[23] = v(0, 0, 32'h0,  0, 0, 32'h0,   0,        4'h0, 32'hC6,         0, 0, 0, 0, 4'h0, 32'h0,   1, 0, 5);

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Table: drive 1ns after the edge, sample 3ns later, before the next edge
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
      d_wdata = vecs[i].dwd; d_be = vecs[i].dbe; mem_rdata = vecs[i].rd;
      #3;
      chk("if_gnt",    i, 32'(if_gnt),    32'(vecs[i].e_ig));
      chk("d_gnt",     i, 32'(d_gnt),     32'(vecs[i].e_dg));
      chk("mem_en",    i, 32'(mem_en),    32'(vecs[i].e_en));
      chk("mem_we",    i, 32'(mem_we),    32'(vecs[i].e_we));
      chk("mem_be",    i, 32'(mem_be),    32'(vecs[i].e_be));
      chk("if_rvalid", i, 32'(if_rvalid), 32'(vecs[i].e_irv));
      chk("d_rvalid",  i, 32'(d_rvalid),  32'(vecs[i].e_drv));
      chk("conflict",  i, 32'(cnt16),     32'(vecs[i].e_cnt));
      if (vecs[i].e_en)  chk("mem_addr",  i, mem_addr,  vecs[i].e_addr);
      if (vecs[i].e_we)  chk("mem_wdata", i, mem_wdata, vecs[i].dwd);
      if (vecs[i].e_irv) chk("if_rdata",  i, if_rdata,  vecs[i].rd);
      if (vecs[i].e_drv) chk("d_rdata",   i, d_rdata,   vecs[i].rd);
    end

    // Saturation: 20 conflict cycles on a 4-bit counter versus a 16-bit one
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    @(posedge clk); #1;
    chk("sat_reset4", 100, 32'(cnt4), 32'd0);
    rst = 1'b0;
    repeat (14) @(posedge clk); #1;
    chk("sat_cnt4_14", 101, 32'(cnt4), 32'd14);
    @(posedge clk); #1;
    chk("sat_cnt4_15", 102, 32'(cnt4), 32'd15);
    repeat (5) @(posedge clk); #1;
    chk("sat_cnt4_hold", 103, 32'(cnt4),  32'd15);
    chk("sat_cnt16_20",  104, 32'(cnt16), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
